// File: rtl/dram_bank_responder.sv
// Cycle-accurate DRAM bank model: per-bank ACTIVATE/PRECHARGE timing FSMs, a bank/row/column
// storage array, a CL-deep read pipeline and a sticky first-error report.
module dram_bank_responder #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int CL           = 3,
  localparam int BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
  localparam int ROW_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1,
  localparam int COL_W  = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cmd,
  input  logic [BANK_W-1:0]       cs,
  input  logic                    rw,
  input  logic [ROW_W-1:0]        row_addr,
  input  logic [COL_W-1:0]        col_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [NUM_OF_BANKS-1:0] bank_open,
  output logic [NUM_OF_BANKS-1:0] bank_busy,
  output logic                    cmd_err,
  output logic [2:0]              err_code
);

  localparam int MEM_DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W     = $clog2(T_MAX + 1);

  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING} state_e;

  state_e             state_q [NUM_OF_BANKS];
  state_e             state_d [NUM_OF_BANKS];
  logic [CNT_W-1:0]   cnt_q   [NUM_OF_BANKS];
  logic [CNT_W-1:0]   cnt_d   [NUM_OF_BANKS];
  logic [ROW_W-1:0]   row_q   [NUM_OF_BANKS];
  logic [ROW_W-1:0]   row_d   [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [CL-1:0]         vld_q;
  logic [DATA_WIDTH-1:0] dat_q [CL];
  logic                  err_q;
  logic [2:0]            code_q;

  logic [31:0]             cs_ext;
  logic                    cs_ok;
  logic [NUM_OF_BANKS-1:0] hit;
  state_e                  sel_state;
  logic [ROW_W-1:0]        sel_row;
  logic                    rd_go;
  logic                    wr_go;
  logic                    err_hit;
  logic [2:0]              err_val;
  logic [IDX_W-1:0]        idx;

  // Command decode against the addressed bank; an out-of-range cs never hits a bank.
  always_comb begin
    cs_ext    = 32'(cs);
    cs_ok     = cs_ext < 32'(NUM_OF_BANKS);
    sel_state = S_IDLE;
    sel_row   = '0;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      hit[b] = cs_ok && (cs_ext == 32'(b));
      if (hit[b]) begin
        sel_state = state_q[b];
        sel_row   = row_q[b];
      end
    end
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    err_hit = 1'b0;
    err_val = 3'd0;
    case (cmd)
      CMD_ACT: if (!cs_ok || sel_state != S_IDLE) begin
        err_hit = 1'b1;
        err_val = 3'd1;
      end
      CMD_RW: if (cs_ok && sel_state == S_ACTIVE) begin
        rd_go = !rw;
        wr_go = rw;
      end else begin
        err_hit = 1'b1;
        err_val = 3'd2;
      end
      CMD_PRE: if (cs_ok && sel_state == S_ACTIVATING) begin
        err_hit = 1'b1;
        err_val = 3'd3;
      end
      default: ;
    endcase
    idx = IDX_W'((int'(cs_ext) * NUM_OF_ROWS + int'(sel_row)) * NUM_OF_COLS + int'(col_addr));
  end

  always_comb begin
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      row_d[b]   = row_q[b];
      case (state_q[b])
        S_ACTIVATING:
          if (cnt_q[b] == CNT_W'(1)) state_d[b] = S_ACTIVE;
          else                       cnt_d[b]   = cnt_q[b] - CNT_W'(1);
        S_PRECHARGING:
          if (cnt_q[b] == CNT_W'(1)) state_d[b] = S_IDLE;
          else                       cnt_d[b]   = cnt_q[b] - CNT_W'(1);
        default: ;
      endcase
      // Accepted commands only ever start from IDLE or ACTIVE, so they never race the countdown.
      if (hit[b] && !err_hit) begin
        if (cmd == CMD_ACT) begin
          row_d[b] = row_addr;
          if (T_RCD == 1) begin
            state_d[b] = S_ACTIVE;
          end else begin
            state_d[b] = S_ACTIVATING;
            cnt_d[b]   = CNT_W'(T_RCD - 1);
          end
        end else if (cmd == CMD_PRE && state_q[b] == S_ACTIVE) begin
          if (T_RP == 1) begin
            state_d[b] = S_IDLE;
          end else begin
            state_d[b] = S_PRECHARGING;
            cnt_d[b]   = CNT_W'(T_RP - 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
        row_q[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        row_q[b]   <= row_d[b];
      end
    end
  end

  always_comb begin
    bank_open = '0;
    bank_busy = '0;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      bank_open[b] = (state_q[b] == S_ACTIVE);
      bank_busy[b] = (state_q[b] == S_ACTIVATING) || (state_q[b] == S_PRECHARGING);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_go) begin
      mem_q[idx] <= wr_data;
    end
  end

  // Read pipeline: data only advances with its valid, so the last stage holds the last read value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < CL; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_go;
      if (rd_go) dat_q[0] <= mem_q[idx];
      for (int i = 1; i < CL; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= 3'd0;
    end else if (err_hit && !err_q) begin
      err_q  <= 1'b1;
      code_q <= err_val;
    end
  end

  assign rd_valid = vld_q[CL-1];
  assign rd_data  = dat_q[CL-1];
  assign cmd_err  = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_dram_bank_responder.sv
// Bench for dram_bank_responder: hand-derived vector table, directed corner sequences and
// random traffic checked against a timestamp-based bank model.
module tb_dram_bank_responder;

  localparam int DW = 1;
  localparam int NB = 8;
  localparam int NR = 128;
  localparam int NC = 8;
  localparam int T_RCD = 2;
  localparam int T_RP = 2;
  localparam int CL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cmd = 2'b00;
  logic [2:0]    cs = '0;
  logic          rw = 1'b0;
  logic [6:0]    row_addr = '0;
  logic [2:0]    col_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [NB-1:0] bank_open;
  logic [NB-1:0] bank_busy;
  logic          cmd_err;
  logic [2:0]    err_code;

  dram_bank_responder #(
    .DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cs(cs), .rw(rw), .row_addr(row_addr),
    .col_addr(col_addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .bank_open(bank_open), .bank_busy(bank_busy), .cmd_err(cmd_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Model: each bank remembers its last accepted ACT (kind 1) or PRE (kind 2) and the edge it happened on.
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  int            kind [NB];
  int            tk   [NB];
  int            krow [NB];
  logic [DW-1:0] mmem [NB][NR][NC];
  rd_t           pend [$];
  int            ep;
  int            m_e;
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic [2:0]    m_code;

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      kind[b] = 0; tk[b] = 0; krow[b] = 0;
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) mmem[b][r][c] = '0;
    end
    pend.delete();
    ep = 0; m_e = -100; m_vld = 0; m_data = '0; m_err = 0; m_code = 0;
  endfunction

  function automatic bit m_idle(int b, int e);
    return kind[b] == 0 || (kind[b] == 2 && e >= tk[b] + T_RP);
  endfunction

  function automatic bit m_active(int b, int e);
    return kind[b] == 1 && e >= tk[b] + T_RCD;
  endfunction

  function automatic void model_edge(logic [1:0] c, int b, logic w, int r, int col, logic [DW-1:0] d);
    int e = ep;
    int code = 0;
    rd_t x;
    case (c)
      2'b01: if (m_idle(b, e)) begin kind[b] = 1; tk[b] = e; krow[b] = r; end
             else code = 1;
      2'b10: if (m_active(b, e)) begin
               if (w) mmem[b][krow[b]][col] = d;
               else begin x.due = e + CL - 1; x.d = mmem[b][krow[b]][col]; pend.push_back(x); end
             end else code = 2;
      2'b11: if (kind[b] == 1 && e < tk[b] + T_RCD) code = 3;
             else if (m_active(b, e)) begin kind[b] = 2; tk[b] = e; end
      default: ;
    endcase
    if (code != 0 && !m_err) begin m_err = 1; m_code = 3'(code); end
    m_vld = 0;
    while (pend.size() > 0 && pend[0].due <= e) begin
      if (pend[0].due == e) begin m_vld = 1; m_data = pend[0].d; end
      void'(pend.pop_front());
    end
    m_e = e;
    ep++;
  endfunction

  task automatic compare_model();
    logic [NB-1:0] eo, eb;
    for (int b = 0; b < NB; b++) begin
      eo[b] = kind[b] == 1 && m_e >= tk[b] + T_RCD - 1;
      eb[b] = (kind[b] == 1 && m_e < tk[b] + T_RCD - 1) || (kind[b] == 2 && m_e < tk[b] + T_RP - 1);
    end
    check("rd_valid", rd_valid, m_vld);
    check("rd_data", rd_data, m_data);
    check("bank_open", bank_open, eo);
    check("bank_busy", bank_busy, eb);
    check("cmd_err", cmd_err, m_err);
    check("err_code", err_code, m_code);
  endtask

  task automatic step(input logic [1:0] c, input int b, input logic w, input int r, input int col,
                      input logic [DW-1:0] d);
    @(negedge clk);
    cmd = c; cs = 3'(b); rw = w; row_addr = 7'(r); col_addr = 3'(col); wr_data = d;
    @(posedge clk);
    model_edge(c, b, w, r, col, d);
    #1;
    compare_model();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 1'b0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd = 2'b00;
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_bank_open", bank_open, 0);
    check("rst_bank_busy", bank_busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_err_code", err_code, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] c; int b; logic w; int r; int col; logic [DW-1:0] d;
    logic vld; logic [DW-1:0] dat; logic [7:0] open; logic err; logic [2:0] code;
  } vec_t;

  vec_t tbl [14];
  int   vcount;

  initial begin
    // cmd bank rw row col wd | rd_valid rd_data bank_open cmd_err err_code (after the edge)
    tbl[0]  = '{2'b01, 3, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
    tbl[2]  = '{2'b10, 3, 1'b1, 0, 2, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
    tbl[3]  = '{2'b10, 3, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
    tbl[4]  = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
    tbl[5]  = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 3'd0};
    tbl[6]  = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 3'd0};
    tbl[7]  = '{2'b01, 5, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 3'd0};
    tbl[8]  = '{2'b10, 5, 1'b0, 0, 2, 1'b0, 1'b0, 1'b1, 8'h28, 1'b1, 3'd2};
    tbl[9]  = '{2'b10, 5, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 8'h28, 1'b1, 3'd2};
    tbl[10] = '{2'b10, 5, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8'h28, 1'b1, 3'd2};
    tbl[11] = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8'h28, 1'b1, 3'd2};
    tbl[12] = '{2'b00, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 8'h28, 1'b1, 3'd2};
    tbl[13] = '{2'b01, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8'h28, 1'b1, 3'd2};

    model_reset();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].c, tbl[i].b, tbl[i].w, tbl[i].r, tbl[i].col, tbl[i].d);
      check($sformatf("tbl%0d_vld", i), rd_valid, tbl[i].vld);
      check($sformatf("tbl%0d_data", i), rd_data, tbl[i].dat);
      check($sformatf("tbl%0d_open", i), bank_open, tbl[i].open);
      check($sformatf("tbl%0d_err", i), cmd_err, tbl[i].err);
      check($sformatf("tbl%0d_code", i), err_code, tbl[i].code);
    end

    // Back-to-back reads of an alternating row
    do_reset();
    step(2'b01, 2, 1'b0, 7, 0, '0);
    nop(1);
    for (int c = 0; c < NC; c++) step(2'b10, 2, 1'b1, 0, c, DW'(c % 2 == 0));
    vcount = 0;
    for (int c = 0; c < NC; c++) begin
      step(2'b10, 2, 1'b0, 0, c, '0);
      if (rd_valid) vcount++;
    end
    for (int i = 0; i < CL; i++) begin
      nop(1);
      if (rd_valid) vcount++;
    end
    check("b2b_valid_count", vcount, NC);

    // Precharge then re-activate exactly at T_RP, and one cycle too early
    do_reset();
    step(2'b01, 0, 1'b0, 3, 0, '0);
    step(2'b01, 1, 1'b0, 4, 0, '0);
    step(2'b11, 0, 1'b0, 0, 0, '0);
    check("pre_open", bank_open, 8'b10);
    nop(1);
    step(2'b01, 0, 1'b0, 9, 0, '0);
    check("react_err", cmd_err, 0);
    check("react_open_a", bank_open, 8'b10);
    nop(1);
    check("react_open_b", bank_open, 8'b11);
    step(2'b11, 0, 1'b0, 0, 0, '0);
    step(2'b01, 0, 1'b0, 9, 0, '0);
    check("early_act_code", err_code, 1);

    // Reset one cycle after a read issue drops it; the array is cleared
    do_reset();
    step(2'b01, 6, 1'b0, 2, 0, '0);
    nop(1);
    step(2'b10, 6, 1'b1, 0, 3, 1'b1);
    step(2'b10, 6, 1'b0, 0, 3, '0);
    nop(1);
    do_reset();
    nop(CL + 1);
    step(2'b01, 6, 1'b0, 2, 0, '0);
    nop(1);
    step(2'b10, 6, 1'b0, 0, 3, '0);
    nop(CL);

    // Precharge of an idle bank is harmless; a second ACT errs and keeps the first row
    do_reset();
    step(2'b11, 4, 1'b0, 0, 0, '0);
    check("pre_idle_err", cmd_err, 0);
    step(2'b01, 4, 1'b0, 11, 0, '0);
    nop(1);
    step(2'b01, 4, 1'b0, 12, 0, '0);
    check("dbl_act_code", err_code, 1);
    check("dbl_act_open", bank_open, 8'h10);
    step(2'b10, 4, 1'b1, 0, 1, 1'b1);
    step(2'b11, 4, 1'b0, 0, 0, '0);
    nop(1);
    step(2'b01, 4, 1'b0, 12, 0, '0);
    nop(1);
    step(2'b10, 4, 1'b0, 0, 1, '0);
    nop(CL);
    step(2'b11, 4, 1'b0, 0, 0, '0);
    nop(1);
    step(2'b01, 4, 1'b0, 11, 0, '0);
    nop(1);
    step(2'b10, 4, 1'b0, 0, 1, '0);
    nop(CL);

    // Random traffic over a few banks and rows
    for (int round = 0; round < 8; round++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        int p;
        logic [1:0] c;
        p = int'($urandom_range(0, 99));
        c = (p < 15) ? 2'b00 : (p < 40) ? 2'b01 : (p < 80) ? 2'b10 : 2'b11;
        step(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, NC - 1)), DW'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_bank_responder.md
Name: dram_bank_responder

Overview:
- Cycle-accurate DRAM device model on the far end of the controller's command interface.
- Decodes per-cycle commands (ACTIVATE, READ/WRITE, PRECHARGE) for a selected bank and enforces row-open/timing rules with one state machine per bank.
- Stores data in a bank/row/column array and returns read data with a fixed CAS latency; this is the stream the controller sees on its data input.
- Flags protocol violations; used as the DUT partner in controller benches.

Parameters:
DATA_WIDTH, 1, bits per column cell
NUM_OF_BANKS, 8, number of banks (BANK_W = clog2)
NUM_OF_ROWS, 128, rows per bank (ROW_W = clog2)
NUM_OF_COLS, 8, columns per row (COL_W = clog2)
T_RCD, 2, ACTIVATE-to-READ/WRITE spacing in cycles, >=1
T_RP, 2, PRECHARGE-to-ACTIVATE spacing in cycles, >=1
CL, 3, READ-to-data latency in cycles, >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd  in  2  00 NOP, 01 ACTIVATE, 10 READ/WRITE, 11 PRECHARGE
cs  in  BANK_W  target bank index
rw  in  1  for cmd 10: 1 write, 0 read
row_addr  in  ROW_W  row for ACTIVATE
col_addr  in  COL_W  column for READ/WRITE
wr_data  in  DATA_WIDTH  write data, sampled with WRITE
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data qualifier
bank_open  out  NUM_OF_BANKS  bit i = bank i ACTIVE
bank_busy  out  NUM_OF_BANKS  bit i = bank i ACTIVATING or PRECHARGING
cmd_err  out  1  sticky protocol-error flag
err_code  out  3  code of the first error

Behaviour:
- Reset, asynchronous:
  - All banks go to IDLE and open rows clear to 0.
  - Array clears to 0 and the read pipeline is flushed.
  - rd_data=0, rd_valid=0, bank_open=0, bank_busy=0, cmd_err=0, err_code=0.
  - Reset mid-operation drops in-flight reads; no rd_valid after release.
- Each rising edge samples one command for bank cs.
- Per-bank FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING. Each bank has its own down-counter.
- ACTIVATE sampled at edge n, bank IDLE:
  - Latch row_addr as the open row.
  - If T_RCD=1: go directly to ACTIVE.
  - Otherwise: go to ACTIVATING, load counter T_RCD-1, decrement each edge, enter ACTIVE on the edge where counter=1.
  - Result: earliest legal READ/WRITE is sampled at edge n+T_RCD, and bank_busy is high for T_RCD-1 cycles.
- PRECHARGE sampled at edge m, bank ACTIVE:
  - Same scheme with T_RP through PRECHARGING to IDLE.
  - Earliest legal ACTIVATE is at edge m+T_RP.
- READ/WRITE (cmd 10), bank ACTIVE:
  - Address is (cs, open row, col_addr).
  - WRITE updates the array at that edge; a READ on the next edge returns the new value.
  - READ enters a CL-deep shift pipeline, so rd_valid=1 and rd_data are valid in the cycle after edge n+CL-1 (CL cycles after the sampling edge).
  - Reads may issue back-to-back every cycle, and the pipeline is fully overlapped.
- rd_data holds its last value while rd_valid=0.
- Banks are independent. Commands to one bank never alter another bank's state or counter.
- Legal no-ops, with no error and no state change: NOP; PRECHARGE to an IDLE or PRECHARGING bank.
- Errors (the offending command is ignored and bank state is unchanged):
  - code 1: ACTIVATE to a non-IDLE bank.
  - code 2: READ/WRITE to a non-ACTIVE bank.
  - code 3: PRECHARGE to an ACTIVATING bank.
- Error reporting:
  - cmd_err sets at the edge after the violation and stays set until reset.
  - err_code captures the first error only; later errors do not overwrite it.
- An out-of-range cs (when NUM_OF_BANKS is not a power of two) is treated as code 2 for cmd 10 and code 1 for cmd 01. PRECHARGE to an out-of-range cs is a no-op.

Test Plan:
- ACT bank 3 row 5 at edge 0; WRITE col 2 data 1 at edge 2; READ col 2 at edge 3 -> rd_valid=1 with rd_data=1 exactly 3 cycles after edge 3, single pulse.
- READ at edge 1 after ACT at edge 0 (T_RCD=2) -> command ignored, cmd_err=1, err_code=2, no rd_valid. A later legal READ still works and err_code stays 2.
- Back-to-back READs to cols 0..7 of an open row preloaded with alternating 1/0 -> 8 consecutive rd_valid cycles with data 1,0,1,0,... starting CL cycles after the first READ.
- ACT bank 0 and ACT bank 1 on consecutive edges, PRE bank 0, then ACT bank 0 row 9 at exactly m+T_RP -> no error, and bank_open reads 0b10 then 0b11. ACT at m+1 instead -> err_code=1.
- Reset asserted 1 cycle after a READ issue -> all outputs 0 immediately. After release, no rd_valid, all banks IDLE, and a READ of a previously written cell returns 0.
- PRECHARGE to an IDLE bank, then ACT twice to the same bank -> no error on the PRECHARGE, err_code=1 on the second ACT, bank remains ACTIVE on the original row.
